// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl -- run-state controller and hazard unit for a 5-stage 16-bit core.
//
// Purpose:
//   Holds the IDLE/RUN/HALT run state, detects load-use hazards between EX and
//   ID, turns taken branches into IF/ID + ID/EX flushes, and keeps two 16-bit
//   performance counters (RUN cycles, stall cycles).
//
// Ports:
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   enable       in   1   run permission; low returns the FSM to IDLE
//   start        in   1   pulse; IDLE -> RUN when enable is high
//   id_ir        in  16   instruction in ID  (opcode [15:11])
//   ex_ir        in  16   instruction in EX  (opcode [15:11])
//   wb_ir        in  16   instruction in WB  (opcode [15:11])
//   branch_taken in   1   taken branch/jump resolved in EX
//   step         in   1   single-step strobe (only with SINGLE_STEP_EN)
//   state        out  1   1 while in RUN
//   advance      out  1   PC and IF/ID may update this cycle
//   stall        out  1   hold PC and IF/ID, bubble into EX
//   flush        out  1   zero IF/ID and ID/EX instruction registers
//   halted       out  1   FSM is in HALT
//   cycle_cnt    out 16   RUN cycles since the last start (wraps)
//   stall_cnt    out 16   stall cycles since the last start (saturates)
//   dbg_state    out  2   raw FSM state (0 IDLE, 1 RUN, 2 HALT)
//
// Configuration:
//   SINGLE_STEP_EN  when defined, adds the step input; advance additionally
//                   requires step=1 and both counters only count step cycles.
//
// Pipeline contract: the fetch/decode stages move forward only on advance.
// stall and flush are combinational for the current cycle; flush wins over
// stall because the instruction that would have stalled is being discarded.
// ----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  input  logic [15:0] wb_ir,
  input  logic        branch_taken,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        state,
  output logic        advance,
  output logic        stall,
  output logic        flush,
  output logic        halted,
  output logic [15:0] cycle_cnt,
  output logic [15:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  // Opcode map of the core's ISA.
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fsm_t;

  fsm_t        state_q, state_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [4:0] id_op, ex_op, wb_op;
  logic       use_a, use_b, use_c;   // ID reads [10:8], [6:4], [2:0]
  logic       hazard;
  logic       in_run;
  logic       cnt_en;
  logic       start_run;

  assign id_op = id_ir[15:11];
  assign ex_op = ex_ir[15:11];
  assign wb_op = wb_ir[15:11];

  // Fields not consumed by this block.
  logic unused_bits;
  assign unused_bits = ^{wb_ir[10:0], ex_ir[7:0], id_ir[7], id_ir[3]};

`ifdef SINGLE_STEP_EN
  assign cnt_en = step;
`else
  assign cnt_en = 1'b1;
`endif

  // Which register fields the ID instruction actually reads. A field that is
  // a destination or an immediate must not raise a hazard.
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    use_c = 1'b0;
    unique case (id_op)
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC,
      OP_JMPR, OP_ADDI, OP_SUBI, OP_LDIH:          use_a = 1'b1;
      OP_STORE:                                    begin use_a = 1'b1; use_b = 1'b1; end
      OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA:     use_b = 1'b1;
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
      OP_CMP, OP_AND, OP_OR, OP_XOR:               begin use_b = 1'b1; use_c = 1'b1; end
      default: ;
    endcase
  end

  assign hazard = (ex_op == OP_LOAD) &&
                  ((use_a && (ex_ir[10:8] == id_ir[10:8])) ||
                   (use_b && (ex_ir[10:8] == id_ir[6:4]))  ||
                   (use_c && (ex_ir[10:8] == id_ir[2:0])));

  assign in_run  = (state_q == ST_RUN);
  assign flush   = in_run && branch_taken;
  assign stall   = in_run && hazard && !branch_taken;
`ifdef SINGLE_STEP_EN
  assign advance = in_run && !stall && step;
`else
  assign advance = in_run && !stall;
`endif
  assign state     = in_run;
  assign halted    = (state_q == ST_HALT);
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

  // Next-state logic. Dropping enable beats HALT detection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && enable) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable)                state_d = ST_IDLE;
        else if (wb_op == OP_HALT)  state_d = ST_HALT;
      end
      ST_HALT: if (!enable)         state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  assign start_run = (state_q == ST_IDLE) && (state_d == ST_RUN);

  // Counters restart on each launch so they describe the current run only.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start_run) begin
      cycle_cnt_d = 16'd0;
      stall_cnt_d = 16'd0;
    end else begin
      if (in_run && cnt_en)
        cycle_cnt_d = cycle_cnt_q + 16'd1;
      if (stall && cnt_en && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; clears all state immediately on assertion.
REQ-003 SHALL have port: enable  input  1  level run permission; 0 forces return to IDLE.
REQ-004 SHALL have port: start  input  1  pulse; leaves IDLE when enable=1.
REQ-005 SHALL have port: id_ir, ex_ir, wb_ir  input  16 each  instruction words in ID, EX and WB stages; opcode field [15:11].
REQ-006 SHALL have port: branch_taken  input  1  taken branch/jump resolved in EX.
REQ-007 SHALL have port: state  output  1  1 = exec (RUN), 0 otherwise; drives stage enables.
REQ-008 SHALL have port: advance  output  1  PC and IF/ID may update this cycle.
REQ-009 SHALL have port: stall  output  1  hold PC and IF/ID; insert bubble (ex_ir=0) into EX.
REQ-010 SHALL have port: flush  output  1  zero the IF/ID and ID/EX instruction registers.
REQ-011 SHALL have port: halted  output  1  FSM in HALT.
REQ-012 SHALL have ports: cycle_cnt, stall_cnt  output  16 each  performance counters.

Function
REQ-013 FSM SHALL have states IDLE, RUN, HALT; registered; reset to IDLE.
REQ-014 Transitions SHALL be: IDLE->RUN on start&enable; RUN->IDLE on !enable; RUN->HALT on wb_ir[15:11]==HALT opcode with enable=1; HALT->IDLE on !enable; all others hold.
REQ-015 !enable SHALL take priority over HALT detection in the same cycle (next state IDLE).
REQ-016 state SHALL be 1 only in RUN; halted SHALL be 1 only in HALT.
REQ-017 Load-use hazard SHALL be: ex_ir op==LOAD and ex_ir[10:8] equals an ID source field: [10:8] for BZ/BNZ/BN/BNN/BC/BNC/JMPR/ADDI/SUBI/LDIH/STORE; [6:4] for LOAD/STORE/ADD/ADDC/SUB/SUBC/CMP/AND/OR/XOR/SLL/SRL/SLA/SRA; [2:0] for ADD/ADDC/SUB/SUBC/CMP/AND/OR/XOR.
REQ-018 stall SHALL be combinational, asserted in RUN on a load-use hazard, exactly one cycle per hazard (bubble clears ex_ir LOAD next cycle).
REQ-019 flush SHALL be combinational, asserted in RUN when branch_taken=1; flush SHALL override stall (stall=0 that cycle).
REQ-020 advance SHALL equal state & !stall (see REQ-026).
REQ-021 cycle_cnt SHALL increment every RUN cycle, wrap 0xFFFF->0x0000.
REQ-022 stall_cnt SHALL increment each cycle stall=1, saturate at 0xFFFF.
REQ-023 Both counters SHALL clear to 0 on the IDLE->RUN transition and hold in IDLE/HALT.
REQ-024 In IDLE/HALT, stall, flush, advance SHALL be 0 regardless of inputs.

Reset
REQ-025 On reset=0 (also mid-RUN): FSM=IDLE, state/advance/stall/flush/halted=0, cycle_cnt=stall_cnt=0, within the same cycle, no clock required.

Configuration
REQ-026 Macro SINGLE_STEP_EN: when defined, adds input step (1 bit) and advance SHALL equal state & !stall & step; stall_cnt/cycle_cnt SHALL count only cycles with step=1; when undefined, no step port and REQ-020 applies unchanged.

Verification
REQ-027 reset=0 mid-RUN with cycle_cnt=0x0010 -> all outputs 0 immediately, FSM IDLE.
REQ-028 start=1, enable=1 from IDLE -> state=1 next cycle; 5 RUN cycles -> cycle_cnt=5; cycle_cnt=0xFFFF +1 -> 0x0000.
REQ-029 ex_ir=LOAD r3, id_ir=ADD r1,r2,r3 -> stall=1, advance=0 one cycle, stall_cnt+1; same with id_ir=ADD r1,r2,r4 -> stall=0.
REQ-030 branch_taken=1 coincident with load-use hazard -> flush=1, stall=0, stall_cnt unchanged.
REQ-031 wb_ir=HALT with enable=1 -> halted=1, state=0 next cycle; same cycle enable=0 -> IDLE, halted=0.
REQ-032 SINGLE_STEP_EN defined, RUN, step=0 for 3 cycles then 1 -> advance=1 only on step cycle, cycle_cnt +1.
